sum_uart_tx: RTL
================

Name: sum_uart_tx

Overview:
Downstream stage for the adder result byte. It buffers incoming 8-bit results in a small FIFO and serialises each one as an 8N1 UART frame on a single output pin. The tile's top level feeds it the sum with a valid/ready handshake and routes `tx` to an output pin, so results can be read off-chip by a host.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 2..65535.
- FIFO_DEPTH, 4, number of byte entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the clk rising edge.
- in_data  input  8  result byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte; equals (fifo_count != FIFO_DEPTH).
- tx  output  1  UART serial line; idle high; driven directly from a flop.
- busy  output  1  high when the FSM is not IDLE or fifo_count != 0.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held; does not include the byte being shifted.
- dropped  output  1  sticky flag; set when in_valid=1 and in_ready=0; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge): tx=1, FSM=IDLE, fifo_count=0, read/write pointers=0, dropped=0, bit/baud counters=0. in_ready=1 and busy=0 from the cycle after reset.
- Reset mid-frame aborts the frame. tx returns to 1 on that same edge. Buffered bytes are discarded.
- Push: on a clk edge with in_valid && in_ready, in_data is written at wr_ptr and wr_ptr increments modulo FIFO_DEPTH.
- Pop: occurs on the edge where FSM=IDLE and fifo_count!=0. The byte at rd_ptr is loaded into the shift register and rd_ptr increments modulo FIFO_DEPTH.
- fifo_count update: a simultaneous push and pop leaves fifo_count unchanged. When full, in_ready=0 even if a pop happens in the same cycle; there is no combinational ready-through.
- Overflow: in_valid && !in_ready drops the byte and sets dropped. FIFO contents are unaffected.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a pop. On the same edge tx<=0 and the baud counter is cleared.
- START: lasts CLKS_PER_BIT cycles with tx=0. Then -> DATA, with tx<=shift[0] and bit index=0.
- DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 -> STOP with tx<=1.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then -> IDLE.
- Latency and frame timing:
  - Byte pushed into an empty FIFO while IDLE at edge N: popped at edge N+1, tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 1 idle cycle between stop bit end and next start bit: the IDLE cycle where the pop occurs. tx stays 1 during it.
- The baud counter is wide enough for CLKS_PER_BIT-1. It wraps to 0 at each bit boundary and never runs free in IDLE.
- in_data is ignored when in_valid=0. X on in_data with in_valid=0 must not propagate.
- busy falls on the edge that returns the FSM to IDLE with fifo_count=0.

Test Plan:
- Single byte, CLKS_PER_BIT=4: push 0x5A at cycle 10 -> tx low from cycle 11 to 14. Then bits 0,1,0,1,1,0,1,0 for 4 cycles each, then stop high for 4 cycles. busy deasserts after cycle 50. dropped=0.
- Burst fill, FIFO_DEPTH=4: push 0x01..0x06 on consecutive cycles. First pop frees one entry, so 0x01–0x05 are accepted. in_ready=0 when fifo_count=4. 0x06 is dropped and dropped=1. Frames arrive in order 0x01..0x05 with a 1-cycle gap between frames.
- Simultaneous push/pop: FIFO holds 1 byte, FSM goes IDLE and pops while a new push is accepted on the same edge -> fifo_count stays 1 and both bytes are transmitted in order.
- Pointer wrap: stream 10 bytes 0x00,0x11..0x99, pacing pushes to keep fifo_count≤2 -> all 10 frames are decoded correctly and dropped=0.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0xFF with 2 bytes queued -> tx=1 on the next edge, fifo_count=0, no further frames. A new push of 0x3C after release transmits cleanly.
- Extremes: 0x00 and 0xFF at CLKS_PER_BIT=2 and 16 -> exact 10*CLKS_PER_BIT frame length, start bit low, stop bit high.

Source files
------------

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: buffers adder result bytes in a small FIFO and sends each one
// as an 8N1 UART frame (start, 8 data bits LSB first, stop) on the tx pin.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic            tx_q, tx_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            dropped_q;

  logic            push, pop;

  // Ready is purely registered state: a full FIFO refuses even while popping.
  assign in_ready   = (cnt_q != CNT_FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == IDLE) && (cnt_q != '0);

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
  assign fifo_count = cnt_q;
  assign dropped    = dropped_q;

  // Occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q <= cnt_d;
      if (in_valid && !in_ready) dropped_q <= 1'b1;
    end
  end

  // Storage is only written on an accepted push, so in_data is never
  // looked at while in_valid is low.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Serialiser state register; reset forces the line idle mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Frame sequencing: each state holds for CLKS_PER_BIT cycles, and tx is
  // loaded one edge ahead so it leaves a flop aligned with the bit period.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (pop) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

endmodule
